fetch_stage: RTL and testbench

//   Instruction fetch front-end feeding the Decode block: owns the PC, issues word reads to the

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front-end: fetch FSM states, reset PC and NOP encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int          PC_WIDTH_DEF    = 32;
    localparam int          INSTR_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and the Decode handshake.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   id_valid;
    logic                   id_ready;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0]    id_pc;
    logic [PC_WIDTH-1:0]    id_pc_plus4;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small register FIFO holding {instruction, pc} pairs between fetch and decode.
// Flush wins over push; the head entry is read straight from the storage registers.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the PC, issues 1-cycle-latency imem reads under a credit
// rule so the buffer never overflows, and restarts at the redirect target on a branch/jump.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter  int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter  int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter  logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
    parameter  int                  FIFO_DEPTH  = 2,
    localparam int                  CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       bus,
    output logic [PC_WIDTH-1:0] fetch_pc_out,
    output logic [CNT_W-1:0]    fifo_count_out
);

    localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;

    state_t              state_reg;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;
    logic                inflight_reg;

    logic                req;
    logic                push;
    logic                flush;
    logic                pop;
    logic                redirect_take;
    logic                head_valid;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy;
    logic [ENTRY_W-1:0]  head_data;
    logic [PC_WIDTH-1:0] head_pc;

    assign redirect_take = bus.redirect_valid && (state_reg != BOOT);
    assign head_valid    = (fifo_count != '0);
    assign pop           = head_valid && bus.id_ready;

    // Entries already buffered plus the one in flight, less the one leaving this cycle.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight_reg}
                     - {{CNT_W{1'b0}}, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:     state_next = RUN;
            RUN:      state_next = bus.redirect_valid ? REDIRECT : RUN;
            REDIRECT: state_next = bus.redirect_valid ? REDIRECT : RUN;
            default:  state_next = BOOT;
        endcase
    end

    // A response landing in a REDIRECT cycle was issued before the redirect and is dropped.
    always_comb begin
        req   = 1'b0;
        push  = 1'b0;
        flush = 1'b0;
        case (state_reg)
            RUN: begin
                req   = !bus.redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
                push  = inflight_reg;
                flush = bus.redirect_valid;
            end
            REDIRECT: begin
                req   = 1'b1;
                flush = bus.redirect_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_next = pc_reg;
        if (redirect_take) begin
            pc_next = bus.redirect_pc & ~PC_WIDTH'(3);
        end else if (req) begin
            pc_next = pc_reg + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= req;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.imem_rdata, pc_reg - PC_WIDTH'(4)}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign head_pc = head_data[PC_WIDTH-1:0];

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_reg;
    assign bus.id_valid    = head_valid;
    assign bus.id_instr    = head_valid ? head_data[PC_WIDTH +: INSTR_WIDTH] : '0;
    assign bus.id_pc       = head_valid ? head_pc : '0;
    assign bus.id_pc_plus4 = head_valid ? head_pc + PC_WIDTH'(4) : '0;

    assign fetch_pc_out   = pc_reg;
    assign fifo_count_out = fifo_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected PCs, a negedge monitor
// pops and checks every delivered instruction (imem returns addr>>2 as data).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc;
    logic [1:0]  fcount;
    logic [31:0] last_addr = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          forbid_en = 1'b0;

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_stage #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .fetch_pc_out   (fetch_pc),
        .fifo_count_out (fcount)
    );

    // Instruction memory: one-cycle latency, data = word index of the address.
    always @(posedge clk) last_addr <= bus.imem_addr;
    assign bus.imem_rdata = last_addr >> 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst && bus.id_valid && bus.id_ready) begin
            logic [31:0] e;
            $display("deliver pc=%h instr=%h pc_plus4=%h", bus.id_pc, bus.id_instr, bus.id_pc_plus4);
            if (forbid_en) begin
                checks++;
                if (bus.id_pc >= 32'h100 && bus.id_pc < 32'h200) begin
                    errors++;
                    $display("FAIL squashed_target actual=%h required=outside 100..1ff", bus.id_pc);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_pc", bus.id_pc, e);
                chk("id_instr", bus.id_instr, e >> 2);
                chk("id_pc_plus4", bus.id_pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // 1: reset state, then streaming at one instruction per cycle
        #12;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0);
        chk("rst_count", 32'(fcount), 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b1;
        tick();
        chk("t1_first_req", 32'(bus.imem_req), 32'd1);
        chk("t1_first_addr", bus.imem_addr, 32'h0);
        tick();
        tick();
        chk("t1_valid_cycle3", 32'(bus.id_valid), 32'd1);
        chk("t1_head_pc", bus.id_pc, 32'h0);
        drain("t1_drain");

        // 2: stall decode, buffer saturates, then release in order
        rst = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_count_full", 32'(fcount), 32'd2);
        chk("t2_req_low", 32'(bus.imem_req), 32'd0);
        chk("t2_id_valid", 32'(bus.id_valid), 32'd1);
        chk("t2_id_pc_stable", bus.id_pc, 32'h0);
        chk("t2_fetch_pc", fetch_pc, 32'h8);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        bus.id_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t2_no_gap", 32'(exp_q.size()), 32'd0);
        drain("t2_drain");

        // 3: redirect with a full buffer
        rst = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        chk("t3_count_flushed", 32'(fcount), 32'd0);
        chk("t3_valid_t1", 32'(bus.id_valid), 32'd0);
        chk("t3_req_t1", 32'(bus.imem_req), 32'd1);
        chk("t3_addr_t1", bus.imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        tick();
        chk("t3_valid_t2", 32'(bus.id_valid), 32'd0);
        tick();
        chk("t3_valid_t3", 32'(bus.id_valid), 32'd1);
        chk("t3_pc_t3", bus.id_pc, 32'h100);
        drain("t3_drain");

        // 3b: redirect mid-stream, in-flight response must be dropped
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t3b_valid_t1", 32'(bus.id_valid), 32'd0);
        chk("t3b_addr_t1", bus.imem_addr, 32'h300);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        tick();
        chk("t3b_valid_t2", 32'(bus.id_valid), 32'd0);
        drain("t3b_drain");

        // 4: back-to-back redirects, unaligned second target
        forbid_en          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_pc    = 32'h203;
        chk("t4_addr_first", bus.imem_addr, 32'h100);
        tick();
        bus.redirect_valid = 1'b0;
        chk("t4_req_second", 32'(bus.imem_req), 32'd1);
        chk("t4_addr_second", bus.imem_addr, 32'h200);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        drain("t4_drain");
        forbid_en = 1'b0;

        // 5: reset with two entries buffered
        bus.id_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_buffered", 32'(fcount), 32'd2);
        rst = 1'b0;
        #1;
        chk("t5_valid_async", 32'(bus.id_valid), 32'd0);
        chk("t5_count_async", 32'(fcount), 32'd0);
        chk("t5_req_async", 32'(bus.imem_req), 32'd0);
        chk("t5_pc_async", fetch_pc, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        bus.id_ready = 1'b1;
        rst = 1'b1;
        drain("t5_drain");

        // 6: PC wrap-around
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drain("t6_drain");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
